// File: rtl/ctrl_saida_pkg.sv
// ctrl_saida_pkg
//   Shared definitions for the sai result bus: controller state encodings,
//   sai code constants (also used by the code-entry FSM), a code classifier
//   and a small integer helper for sizing the pulse timer.
package ctrl_saida_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TRACK = 3'd1,
    S_ACAO  = 3'd2,
    S_HORA  = 3'd3,
    S_ALARM = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    K_NONE = 3'd0,
    K_POS  = 3'd1,
    K_ERR  = 3'd2,
    K_ACAO = 3'd3,
    K_HORA = 3'd4
  } kind_t;

  localparam logic [3:0] COD_P1   = 4'b0001;
  localparam logic [3:0] COD_P2   = 4'b0010;
  localparam logic [3:0] COD_P3   = 4'b0011;
  localparam logic [3:0] COD_P4   = 4'b0100;
  localparam logic [3:0] COD_P5   = 4'b0101;
  localparam logic [3:0] COD_ERR  = 4'b1000;
  localparam logic [3:0] COD_ACAO = 4'b1001;
  localparam logic [3:0] COD_HORA = 4'b1010;

  function automatic kind_t decode(input logic [3:0] c);
    kind_t k;
    case (c)
      COD_P1, COD_P2, COD_P3, COD_P4, COD_P5: k = K_POS;
      COD_ERR:  k = K_ERR;
      COD_ACAO: k = K_ACAO;
      COD_HORA: k = K_HORA;
      default:  k = K_NONE;
    endcase
    return k;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ctrl_saida_pulse_timer.sv
// pulse_timer
//   Loadable down-counter. Loads load_val when load is high, otherwise counts
//   down and parks at zero. expired is high while the count is zero.
// Ports
//   clk       system clock
//   rst       synchronous active-low reset (count cleared)
//   load      load request
//   load_val  value loaded (pulse length minus one)
//   expired   count == 0
module pulse_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/ctrl_saida.sv
// ctrl_saida
//   Consumer of the code FSM result bus. Each change of sai is one event;
//   events become position LEDs, timed action/hour pulses and an error alarm
//   with a saturating error counter. All outputs are registered.
// Ports
//   clk       system clock
//   rst       synchronous active-low reset
//   sai       held-level code bus from the code FSM
//   led       one-hot current position (bit P-1), 0 = none
//   last_pos  last accepted position 1..5, 0 after reset
//   acao      action pulse, ACAO_CYC cycles
//   hora      hour pulse, HORA_CYC cycles
//   alarm     error pulse, ALARM_CYC cycles, retriggerable
//   busy      high in ACAO/HORA/ALARM
//   err_cnt   saturating error event count
//
// state   | meaning
// S_IDLE  | no position known, waiting for a position code
// S_TRACK | tracking position, action/hour codes accepted
// S_ACAO  | action pulse running, only ERR accepted
// S_HORA  | hour pulse running, only ERR accepted
// S_ALARM | alarm pulse running, ERR retriggers
module ctrl_saida
  import ctrl_saida_pkg::*;
#(
  parameter int ACAO_CYC  = 16,
  parameter int HORA_CYC  = 32,
  parameter int ALARM_CYC = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       sai,
  output logic [4:0]       led,
  output logic [2:0]       last_pos,
  output logic             acao,
  output logic             hora,
  output logic             alarm,
  output logic             busy,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int TMAX = max3(ACAO_CYC, HORA_CYC, ALARM_CYC);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]    LD_ACAO  = TW'(ACAO_CYC - 1);
  localparam logic [TW-1:0]    LD_HORA  = TW'(HORA_CYC - 1);
  localparam logic [TW-1:0]    LD_ALARM = TW'(ALARM_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state, st_eff, st_n;
  logic [3:0]       code_q;
  logic             new_evt;
  kind_t            kind;
  logic             expired;
  logic             t_load;
  logic [TW-1:0]    t_val;
  logic [4:0]       led_n;
  logic [2:0]       last_n;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] cnt_inc;

  // code_q also follows sai during reset, so a code held through reset is
  // not mistaken for a fresh event when reset is released.
  always_ff @(posedge clk) begin
    code_q <= sai;
  end

  assign new_evt = (sai != code_q);
  assign kind    = decode(sai);
  assign cnt_inc = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + CNT_W'(1);

  pulse_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .expired  (expired)
  );

  always_comb begin
    st_eff = state;
    led_n  = led;
    last_n = last_pos;
    cnt_n  = err_cnt;
    t_load = 1'b0;
    t_val  = '0;

    // A pulse that ends this cycle hands the event to the state it returns to.
    if ((state == S_ACAO || state == S_HORA) && expired) begin
      st_eff = S_TRACK;
    end else if (state == S_ALARM && expired) begin
      st_eff = S_IDLE;
    end
    st_n = st_eff;

    if (new_evt) begin
      case (st_eff)
        S_IDLE: begin
          if (kind == K_POS) begin
            st_n   = S_TRACK;
            led_n  = 5'b00001 << (sai[2:0] - 3'd1);
            last_n = sai[2:0];
          end else if (kind == K_ERR || kind == K_ACAO || kind == K_HORA) begin
            st_n   = S_ALARM;
            t_load = 1'b1;
            t_val  = LD_ALARM;
            cnt_n  = cnt_inc;
          end
        end
        S_TRACK: begin
          case (kind)
            K_POS: begin
              led_n  = 5'b00001 << (sai[2:0] - 3'd1);
              last_n = sai[2:0];
            end
            K_ACAO: begin
              st_n   = S_ACAO;
              t_load = 1'b1;
              t_val  = LD_ACAO;
            end
            K_HORA: begin
              st_n   = S_HORA;
              t_load = 1'b1;
              t_val  = LD_HORA;
            end
            K_ERR: begin
              st_n   = S_ALARM;
              t_load = 1'b1;
              t_val  = LD_ALARM;
              cnt_n  = cnt_inc;
            end
            default: ;
          endcase
        end
        S_ACAO, S_HORA, S_ALARM: begin
          if (kind == K_ERR) begin
            st_n   = S_ALARM;
            t_load = 1'b1;
            t_val  = LD_ALARM;
            cnt_n  = cnt_inc;
          end
        end
        default: ;
      endcase
    end

    if (st_n == S_ALARM) begin
      led_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      led      <= '0;
      last_pos <= '0;
      acao     <= 1'b0;
      hora     <= 1'b0;
      alarm    <= 1'b0;
      busy     <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= st_n;
      led      <= led_n;
      last_pos <= last_n;
      acao     <= (st_n == S_ACAO);
      hora     <= (st_n == S_HORA);
      alarm    <= (st_n == S_ALARM);
      busy     <= (st_n == S_ACAO) || (st_n == S_HORA) || (st_n == S_ALARM);
      err_cnt  <= cnt_n;
    end
  end

endmodule

// File: tb/tb_ctrl_saida.sv
module tb_ctrl_saida;

  logic       clk;
  logic       rst;
  logic [3:0] sai;
  logic [4:0] led;
  logic [2:0] last_pos;
  logic       acao;
  logic       hora;
  logic       alarm;
  logic       busy;
  logic [1:0] err_cnt;

  int errors = 0;
  int checks = 0;

  ctrl_saida #(
    .ACAO_CYC  (16),
    .HORA_CYC  (32),
    .ALARM_CYC (8),
    .CNT_W     (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sai      (sai),
    .led      (led),
    .last_pos (last_pos),
    .acao     (acao),
    .hora     (hora),
    .alarm    (alarm),
    .busy     (busy),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] code);
    rst = 1'b0;
    sai = code;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [13:0] all;
    rst = 1'b0;
    sai = 4'b1001;
    repeat (3) tick();
    all = {led, last_pos, acao, hora, alarm, busy, err_cnt};
    checks++;
    if (all !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", all, 14'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({acao, alarm, busy, led} !== 8'd0) begin
        errors++;
        $display("FAIL reset_release_quiet cyc=%0d got=%b exp=%b", i, {acao, alarm, busy, led}, 8'd0);
      end
    end
  endtask

  task automatic test_pos();
    sai = 4'b0000;
    tick();
    checks++;
    if ({led, busy} !== 6'd0) begin
      errors++;
      $display("FAIL pos_ignored_code got=%b exp=%b", {led, busy}, 6'd0);
    end
    sai = 4'b0001;
    tick();
    checks++;
    if (led !== 5'b00001 || last_pos !== 3'd1) begin
      errors++;
      $display("FAIL pos1 led=%b last=%0d exp led=00001 last=1", led, last_pos);
    end
    sai = 4'b0010;
    tick();
    checks++;
    if (led !== 5'b00010 || last_pos !== 3'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pos2 led=%b last=%0d busy=%b exp led=00010 last=2 busy=0", led, last_pos, busy);
    end
  endtask

  task automatic test_acao();
    int n = 0;
    int busy_bad = 0;
    sai = 4'b1001;
    tick();
    while (acao === 1'b1 && n < 50) begin
      n++;
      if (busy !== 1'b1) busy_bad++;
      tick();
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL acao_len got=%0d exp=%0d", n, 16);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL acao_busy low_cycles=%0d exp=0", busy_bad);
    end
    checks++;
    if (led !== 5'b00010 || busy !== 1'b0 || acao !== 1'b0) begin
      errors++;
      $display("FAIL acao_return led=%b busy=%b acao=%b exp led=00010 busy=0 acao=0", led, busy, acao);
    end
  endtask

  task automatic test_hora_err();
    int n = 0;
    sai = 4'b1010;
    tick();
    sai = 4'b0011;
    tick();
    checks++;
    if (hora !== 1'b1 || led !== 5'b00010 || last_pos !== 3'd2) begin
      errors++;
      $display("FAIL hora_pos_dropped hora=%b led=%b last=%0d exp hora=1 led=00010 last=2", hora, led, last_pos);
    end
    repeat (2) tick();
    sai = 4'b1000;
    tick();
    checks++;
    if (hora !== 1'b0 || alarm !== 1'b1 || led !== 5'd0 || err_cnt !== 2'd1) begin
      errors++;
      $display("FAIL hora_err hora=%b alarm=%b led=%b cnt=%0d exp hora=0 alarm=1 led=0 cnt=1", hora, alarm, led, err_cnt);
    end
    while (alarm === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL alarm_len got=%0d exp=%0d", n, 8);
    end
    checks++;
    if (busy !== 1'b0 || led !== 5'd0 || err_cnt !== 2'd1) begin
      errors++;
      $display("FAIL alarm_end busy=%b led=%b cnt=%0d exp busy=0 led=0 cnt=1", busy, led, err_cnt);
    end
  endtask

  task automatic test_retrigger();
    int n = 0;
    do_reset(4'b0000);
    sai = 4'b1000;
    tick();
    n = 1;
    sai = 4'b0000;
    while (n < 5) begin
      tick();
      n++;
    end
    checks++;
    if (alarm !== 1'b1 || err_cnt !== 2'd1) begin
      errors++;
      $display("FAIL retrig_c5 alarm=%b cnt=%0d exp alarm=1 cnt=1", alarm, err_cnt);
    end
    sai = 4'b1000;
    tick();
    while (alarm === 1'b1 && n < 60) begin
      n++;
      tick();
    end
    checks++;
    if (n != 13) begin
      errors++;
      $display("FAIL retrig_len got=%0d exp=%0d", n, 13);
    end
    checks++;
    if (err_cnt !== 2'd2) begin
      errors++;
      $display("FAIL retrig_cnt got=%0d exp=%0d", err_cnt, 2);
    end
  endtask

  task automatic test_idle_illegal();
    sai = 4'b1001;
    tick();
    checks++;
    if (alarm !== 1'b1 || acao !== 1'b0 || err_cnt !== 2'd3) begin
      errors++;
      $display("FAIL idle_acao alarm=%b acao=%b cnt=%0d exp alarm=1 acao=0 cnt=3", alarm, acao, err_cnt);
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset(4'b0000);
    for (int i = 0; i < 5; i++) begin
      exp_cnt = (i + 1 > 3) ? 3 : i + 1;
      sai = 4'b1000;
      tick();
      checks++;
      if (err_cnt !== exp_cnt[1:0] || alarm !== 1'b1) begin
        errors++;
        $display("FAIL sat_evt%0d cnt=%0d alarm=%b exp cnt=%0d alarm=1", i, err_cnt, alarm, exp_cnt);
      end
      repeat (10) tick();
      checks++;
      if (err_cnt !== exp_cnt[1:0] || alarm !== 1'b0) begin
        errors++;
        $display("FAIL sat_hold%0d cnt=%0d alarm=%b exp cnt=%0d alarm=0", i, err_cnt, alarm, exp_cnt);
      end
      sai = 4'b0000;
      tick();
    end
    sai = 4'b1000;
    tick();
    repeat (7) tick();
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL alarm_last_cycle got=%b exp=1", alarm);
    end
    sai = 4'b0011;
    tick();
    checks++;
    if (led !== 5'b00100 || alarm !== 1'b0 || busy !== 1'b0 || last_pos !== 3'd3 || err_cnt !== 2'd3) begin
      errors++;
      $display("FAIL alarm_exp_pos led=%b alarm=%b busy=%b last=%0d cnt=%0d exp led=00100 alarm=0 busy=0 last=3 cnt=3",
               led, alarm, busy, last_pos, err_cnt);
    end
  endtask

  task automatic test_hora_expiry_pos();
    sai = 4'b0001;
    tick();
    sai = 4'b1010;
    tick();
    repeat (31) tick();
    checks++;
    if (hora !== 1'b1 || led !== 5'b00001) begin
      errors++;
      $display("FAIL hora_last_cycle hora=%b led=%b exp hora=1 led=00001", hora, led);
    end
    sai = 4'b0011;
    tick();
    checks++;
    if (hora !== 1'b0 || led !== 5'b00100 || busy !== 1'b0 || last_pos !== 3'd3) begin
      errors++;
      $display("FAIL hora_exp_pos hora=%b led=%b busy=%b last=%0d exp hora=0 led=00100 busy=0 last=3", hora, led, busy, last_pos);
    end
    tick();
    checks++;
    if (hora !== 1'b0 || led !== 5'b00100) begin
      errors++;
      $display("FAIL hora_no_replay hora=%b led=%b exp hora=0 led=00100", hora, led);
    end
  endtask

  task automatic test_reset_mid();
    sai = 4'b1001;
    tick();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({acao, busy, led, last_pos} !== 10'd0) begin
      errors++;
      $display("FAIL reset_mid got=%b exp=%b", {acao, busy, led, last_pos}, 10'd0);
    end
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({acao, alarm, busy} !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_release got=%b exp=%b", {acao, alarm, busy}, 3'd0);
    end
  endtask

  initial begin
    rst = 1'b0;
    sai = 4'b0000;
    test_reset();
    test_pos();
    test_acao();
    test_hora_err();
    test_retrigger();
    test_idle_illegal();
    test_saturation();
    test_hora_expiry_pos();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
